// File: rtl/machine_arms_n_logic.sv
// N-arm running-mean estimator: per-arm pull count and reward sum, mean via a
// restoring divider, one sample in flight at a time.

module machine_arms_n_logic_slot #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16,
  parameter int SUM_W  = DATA_W + CNT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear_i,
  input  logic              upd_en_i,
  input  logic [DATA_W-1:0] reward_i,
  output logic [SUM_W-1:0]  sum_o,
  output logic [CNT_W-1:0]  cnt_o
);
  logic [SUM_W-1:0] sum_q, sum_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    sum_d = sum_q;
    cnt_d = cnt_q;
    if (clear_i) begin
      sum_d = '0;
      cnt_d = '0;
    end else if (upd_en_i) begin
      sum_d = sum_q + SUM_W'(reward_i);
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q <= '0;
      cnt_q <= '0;
    end else begin
      sum_q <= sum_d;
      cnt_q <= cnt_d;
    end
  end

  assign sum_o = sum_q;
  assign cnt_o = cnt_q;
endmodule

module machine_arms_n_logic #(
  parameter int NUM_ARMS = 2,
  parameter int ARM_W    = (NUM_ARMS > 1) ? $clog2(NUM_ARMS) : 1,
  parameter int DATA_W   = 32,
  parameter int CNT_W    = 16,
  parameter int SUM_W    = DATA_W + CNT_W
) (
  input  logic              clk,
  input  logic              s_aresetn,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ARM_W-1:0]  in_arm,
  input  logic [DATA_W-1:0] in_reward,
  output logic              q_valid,
  output logic [ARM_W-1:0]  q_arm,
  output logic [DATA_W-1:0] q_value,
  output logic [CNT_W-1:0]  q_count,
  output logic              err_arm
);
  localparam int IT_W = $clog2(SUM_W + 1);
  localparam logic [ARM_W:0] NARM = (ARM_W+1)'(NUM_ARMS);

  typedef enum logic [1:0] {IDLE, ACCUM, DIVIDE, OUTPUT} state_e;
  state_e state_q, state_d;

  logic [ARM_W-1:0]  arm_q;
  logic [DATA_W-1:0] rew_q;
  logic [CNT_W-1:0]  rem_q, dvs_q;
  logic [SUM_W-1:0]  quo_q;
  logic [IT_W-1:0]   it_q;
  logic              qv_q, err_q;
  logic [ARM_W-1:0]  q_arm_q;
  logic [DATA_W-1:0] q_value_q;
  logic [CNT_W-1:0]  q_count_q;

  logic [NUM_ARMS-1:0][SUM_W-1:0] sum_a;
  logic [NUM_ARMS-1:0][CNT_W-1:0] cnt_a;
  logic [NUM_ARMS-1:0]            upd_en;

  logic [SUM_W-1:0] sum_sel, sum_new;
  logic [CNT_W-1:0] cnt_sel, cnt_new;
  logic             sat, accept, arm_ok;
  logic [CNT_W:0]   rem_sh;
  logic             ge;

  assign in_ready = (state_q == IDLE) && !clear && s_aresetn;
  assign accept   = in_valid && in_ready;
  assign arm_ok   = {1'b0, in_arm} < NARM;

  // Arm state lives in per-arm slots; only the captured arm updates in ACCUM.
  for (genvar i = 0; i < NUM_ARMS; i++) begin : g_arm
    assign upd_en[i] = (state_q == ACCUM) && (arm_q == ARM_W'(i)) && !sat;
    machine_arms_n_logic_slot #(.DATA_W(DATA_W), .CNT_W(CNT_W), .SUM_W(SUM_W)) u_slot (
      .clk(clk), .rst_n(s_aresetn), .clear_i(clear), .upd_en_i(upd_en[i]),
      .reward_i(rew_q), .sum_o(sum_a[i]), .cnt_o(cnt_a[i])
    );
  end

  always_comb begin
    sum_sel = '0;
    cnt_sel = '0;
    for (int i = 0; i < NUM_ARMS; i++) begin
      if (arm_q == ARM_W'(i)) begin
        sum_sel = sum_a[i];
        cnt_sel = cnt_a[i];
      end
    end
  end

  // A saturated counter drops the sample but still reports the current mean.
  assign sat     = &cnt_sel;
  assign sum_new = sat ? sum_sel : sum_sel + SUM_W'(rew_q);
  assign cnt_new = sat ? cnt_sel : cnt_sel + 1'b1;

  assign rem_sh = {rem_q, quo_q[SUM_W-1]};
  assign ge     = rem_sh >= {1'b0, dvs_q};

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept && arm_ok) state_d = ACCUM;
      ACCUM:   state_d = DIVIDE;
      DIVIDE:  if (it_q == '0) state_d = OUTPUT;
      OUTPUT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (clear) state_d = IDLE;
  end

  always_ff @(posedge clk or negedge s_aresetn) begin
    if (!s_aresetn) begin
      state_q   <= IDLE;
      arm_q     <= '0;
      rew_q     <= '0;
      rem_q     <= '0;
      dvs_q     <= '0;
      quo_q     <= '0;
      it_q      <= '0;
      qv_q      <= 1'b0;
      err_q     <= 1'b0;
      q_arm_q   <= '0;
      q_value_q <= '0;
      q_count_q <= '0;
    end else begin
      state_q <= state_d;
      qv_q    <= 1'b0;
      err_q   <= 1'b0;
      if (!clear) begin
        unique case (state_q)
          IDLE: if (accept) begin
            arm_q <= in_arm;
            rew_q <= in_reward;
            err_q <= !arm_ok;
          end
          ACCUM: begin
            quo_q <= sum_new;
            dvs_q <= cnt_new;
            rem_q <= '0;
            it_q  <= IT_W'(SUM_W - 1);
          end
          DIVIDE: begin
            rem_q <= ge ? CNT_W'(rem_sh - {1'b0, dvs_q}) : rem_sh[CNT_W-1:0];
            quo_q <= {quo_q[SUM_W-2:0], ge};
            it_q  <= it_q - 1'b1;
          end
          OUTPUT: begin
            qv_q      <= 1'b1;
            q_arm_q   <= arm_q;
            q_value_q <= quo_q[DATA_W-1:0];
            q_count_q <= dvs_q;
          end
          default: ;
        endcase
      end
    end
  end

  assign q_valid = qv_q;
  assign err_arm = err_q;
  assign q_arm   = q_arm_q;
  assign q_value = q_value_q;
  assign q_count = q_count_q;
endmodule

// File: tb/tb_machine_arms_n_logic.sv
// Scoreboard bench for machine_arms_n_logic: 3 arms, 4-bit counters so the
// saturation and bad-index paths are reachable in one configuration.

module tb_machine_arms_n_logic;
  localparam int NA = 3;
  localparam int AW = 2;
  localparam int DW = 32;
  localparam int CW = 4;
  localparam int SW = DW + CW;

  logic          clk = 1'b0;
  logic          s_aresetn, clear, in_valid, in_ready, q_valid, err_arm;
  logic [AW-1:0] in_arm, q_arm;
  logic [DW-1:0] in_reward, q_value;
  logic [CW-1:0] q_count;

  machine_arms_n_logic #(.NUM_ARMS(NA), .DATA_W(DW), .CNT_W(CW)) dut (
    .clk(clk), .s_aresetn(s_aresetn), .clear(clear), .in_valid(in_valid),
    .in_ready(in_ready), .in_arm(in_arm), .in_reward(in_reward),
    .q_valid(q_valid), .q_arm(q_arm), .q_value(q_value), .q_count(q_count),
    .err_arm(err_arm)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] arm;
    logic [DW-1:0] val;
    logic [CW-1:0] cnt;
  } exp_t;

  exp_t        sb[$];
  logic [63:0] msum[NA];
  int          mcnt[NA];
  int          n_cmp = 0, n_err = 0, n_qv = 0, cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic mdl_clear();
    for (int i = 0; i < NA; i++) begin
      msum[i] = '0;
      mcnt[i] = 0;
    end
  endtask

  // Every q_valid pulse pops one expected result.
  always @(negedge clk) begin
    if (q_valid) begin
      exp_t e;
      n_qv++;
      if (sb.size() == 0) chk("unexpected_qv", 64'(1), 64'(0));
      else begin
        e = sb.pop_front();
        chk("q_arm", 64'(q_arm), 64'(e.arm));
        chk("q_value", 64'(q_value), 64'(e.val));
        chk("q_count", 64'(q_count), 64'(e.cnt));
      end
    end
  end

  task automatic accept(input int arm, input logic [DW-1:0] rw, output int acc);
    int t;
    t = 0;
    while (!in_ready && t < 200) begin @(negedge clk); t++; end
    chk("ready_wait", 64'(t < 200), 64'(1));
    in_arm = AW'(arm); in_reward = rw; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    acc = cyc;
  endtask

  task automatic send(input int arm, input logic [DW-1:0] rw);
    int t, acc, nq;
    bit busy_ok;
    exp_t e;
    accept(arm, rw, acc);
    if (arm >= NA) begin
      nq = n_qv;
      chk("err_pulse", 64'(err_arm), 64'(1));
      chk("err_ready", 64'(in_ready), 64'(1));
      @(negedge clk);
      chk("err_once", 64'(err_arm), 64'(0));
      repeat (SW + 6) @(negedge clk);
      chk("err_no_qv", 64'(n_qv - nq), 64'(0));
      return;
    end
    if (mcnt[arm] < (1 << CW) - 1) begin
      mcnt[arm]++;
      msum[arm] += 64'(rw);
    end
    e.arm = AW'(arm);
    e.val = DW'(msum[arm] / 64'(mcnt[arm]));
    e.cnt = CW'(mcnt[arm]);
    sb.push_back(e);
    busy_ok = 1'b1;
    t = 0;
    while (!q_valid && t < 100) begin
      if (in_ready) busy_ok = 1'b0;
      @(negedge clk);
      t++;
    end
    chk("busy_not_ready", 64'(busy_ok), 64'(1));
    chk("latency", 64'(cyc - acc), 64'(SW + 2));
    @(negedge clk);
    chk("qv_one_cycle", 64'(q_valid), 64'(0));
  endtask

  task automatic abort(input int arm, input logic [DW-1:0] rw, input bit use_rst);
    int acc, nq;
    nq = n_qv;
    accept(arm, rw, acc);
    repeat (19) @(negedge clk);
    if (use_rst) s_aresetn = 1'b0; else clear = 1'b1;
    @(negedge clk);
    s_aresetn = 1'b1; clear = 1'b0;
    mdl_clear();
    repeat (SW + 10) @(negedge clk);
    chk(use_rst ? "rst_abort_no_qv" : "clr_abort_no_qv", 64'(n_qv - nq), 64'(0));
    if (use_rst) begin
      chk("rst_abort_qvalue", 64'(q_value), 64'(0));
      chk("rst_abort_qcount", 64'(q_count), 64'(0));
    end
    send(arm, 32'h0000_0007);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    s_aresetn = 1'b0; clear = 1'b0; in_valid = 1'b0; in_arm = '0; in_reward = '0;
    mdl_clear();
    repeat (3) @(negedge clk);
    chk("rst_ready", 64'(in_ready), 64'(0));
    chk("rst_qvalid", 64'(q_valid), 64'(0));
    chk("rst_err", 64'(err_arm), 64'(0));
    chk("rst_qvalue", 64'(q_value), 64'(0));
    chk("rst_qcount", 64'(q_count), 64'(0));
    s_aresetn = 1'b1;
    @(negedge clk);
    chk("idle_ready", 64'(in_ready), 64'(1));

    send(1, 32'h0001_0000);
    send(1, 32'h0003_0000);
    send(0, 32'h0000_0001);
    send(0, 32'h0000_0002);
    send(2, 32'hFFFF_FFFF);
    send(1, 32'h0000_0000);

    send(3, 32'h1234_5678);
    send(2, 32'h0000_0004);

    clear = 1'b1;
    @(negedge clk);
    chk("clear_blocks_ready", 64'(in_ready), 64'(0));
    clear = 1'b0;
    mdl_clear();
    for (int i = 0; i < 16; i++) send(0, 32'h0000_0005);

    abort(1, 32'h0000_0009, 1'b0);
    abort(2, 32'h0000_000B, 1'b1);

    repeat (4) @(negedge clk);
    chk("sb_drained", 64'(sb.size()), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
